// File: rtl/ftdi_pkg.sv
// Shared definitions for the FT245-style FTDI bus arbiter: state encoding,
// direction constants and default timing.
package ftdi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdStrobe,
        StWrSetup,
        StWrStrobe,
        StWrHold,
        StRecover
    } ftdi_state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    localparam int unsigned DEF_RD_PULSE       = 4;
    localparam int unsigned DEF_WR_PULSE       = 4;
    localparam int unsigned DEF_RECOVER_CYCLES = 3;
    localparam int unsigned DEF_BURST_MAX      = 16;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ftdi_sync2.sv
// Two-flop synchronizer for the asynchronous FTDI status flags.
module ftdi_sync2 (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/ftdi_bus_arbiter.sv
// Half-duplex FT245 bus sequencer: arbitrates host reads against host writes with a
// bounded burst and generates pop/push strobes, bus output enable and FIFO strobes.
module ftdi_bus_arbiter
    import ftdi_pkg::*;
#(
    parameter int unsigned RD_PULSE       = DEF_RD_PULSE,
    parameter int unsigned WR_PULSE       = DEF_WR_PULSE,
    parameter int unsigned RECOVER_CYCLES = DEF_RECOVER_CYCLES,
    parameter int unsigned BURST_MAX      = DEF_BURST_MAX
) (
    input  logic       clk_pll,
    input  logic       reset,
    input  logic       FTDI_data_avilable,
    input  logic       FTDI_empty_for_write,
    output logic       FTDI_pop_data,
    output logic       FTDI_push_data,
    input  logic [7:0] FTDI_data_in,
    output logic [7:0] FTDI_data_out,
    output logic       FTDI_data_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_full,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_pop,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(max3(RD_PULSE, WR_PULSE, RECOVER_CYCLES)) + 1;
    localparam int unsigned BC_W  = $clog2(BURST_MAX) + 1;

    logic              w_avail_s;
    logic              w_wspace_s;
    logic              w_rd_req;
    logic              w_wr_req;
    logic              w_grant;
    logic              w_grant_dir;
    logic [BC_W-1:0]   w_burst_d;
    ftdi_state_e       r_state;
    ftdi_state_e       w_state_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_d;
    logic              r_last_dir;
    logic [BC_W-1:0]   r_burst_cnt;
    logic [7:0]        r_data_out;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;

    ftdi_sync2 u_sync_avail (
        .i_clk   (clk_pll),
        .i_reset (reset),
        .i_async (FTDI_data_avilable),
        .o_sync  (w_avail_s)
    );

    ftdi_sync2 u_sync_wspace (
        .i_clk   (clk_pll),
        .i_reset (reset),
        .i_async (FTDI_empty_for_write),
        .o_sync  (w_wspace_s)
    );

    assign w_rd_req = w_avail_s & ~rx_full;
    assign w_wr_req = w_wspace_s & ~tx_empty;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_grant     = 1'b0;
        w_grant_dir = DIR_RD;
        w_burst_d   = r_burst_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_rd_req || w_wr_req) begin
                    w_grant = 1'b1;
                    if (w_rd_req && w_wr_req) begin
                        w_grant_dir = (r_burst_cnt < BC_W'(BURST_MAX)) ? r_last_dir : ~r_last_dir;
                    end else begin
                        w_grant_dir = w_wr_req ? DIR_WR : DIR_RD;
                    end
                    if (w_grant_dir != r_last_dir) begin
                        w_burst_d = BC_W'(1);
                    end else if (r_burst_cnt < BC_W'(BURST_MAX)) begin
                        w_burst_d = r_burst_cnt + BC_W'(1);
                    end
                    if (w_grant_dir == DIR_RD) begin
                        w_state_d = StRdStrobe;
                        w_cnt_d   = CNT_W'(RD_PULSE - 1);
                    end else begin
                        w_state_d = StWrSetup;
                    end
                end
            end
            StRdStrobe: begin
                if (r_cnt == '0) begin
                    w_state_d = StRecover;
                    w_cnt_d   = CNT_W'(RECOVER_CYCLES - 1);
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            StWrSetup: begin
                w_state_d = StWrStrobe;
                w_cnt_d   = CNT_W'(WR_PULSE - 1);
            end
            StWrStrobe: begin
                if (r_cnt == '0) begin
                    w_state_d = StWrHold;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            StWrHold: begin
                w_state_d = StRecover;
                w_cnt_d   = CNT_W'(RECOVER_CYCLES - 1);
            end
            StRecover: begin
                if (r_cnt == '0) begin
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_last_dir  <= DIR_RD;
            r_burst_cnt <= '0;
            r_data_out  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_grant) begin
                r_last_dir  <= w_grant_dir;
                r_burst_cnt <= w_burst_d;
            end
            if (w_grant && (w_grant_dir == DIR_WR)) begin
                r_data_out <= tx_data;
            end
            if ((r_state == StRdStrobe) && (r_cnt == '0)) begin
                r_rx_data <= FTDI_data_in;
            end
            r_rx_valid <= (r_state == StRdStrobe) && (r_cnt == '0);
        end
    end

    assign FTDI_pop_data  = (r_state == StRdStrobe);
    assign FTDI_push_data = (r_state == StWrStrobe);
    assign FTDI_data_oe   = (r_state == StWrSetup) || (r_state == StWrStrobe) ||
                            (r_state == StWrHold);
    assign FTDI_data_out  = r_data_out;
    assign rx_data        = r_rx_data;
    assign rx_valid       = r_rx_valid;
    // Gated by reset so a grant coinciding with reset cannot drop an egress byte.
    assign tx_pop         = w_grant && (w_grant_dir == DIR_WR) && !reset;
    assign busy           = (r_state != StIdle);

endmodule
